// File: rtl/vram_ctrl.sv
// Single-port video RAM shared by a preload stream, one write port and NUM_RD read channels.
// Define VRAM_PRELOAD_EN to enable the post-reset LOAD phase that fills the array sequentially.
module vram_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ld_valid,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  output logic                     loaded,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int RR_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int CW    = RR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              loaded_q, loaded_d;
  logic              ld_ready_q, ld_ready_d;
  logic              ld_beat;
  logic [ADDR_W-1:0] ld_addr;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic              last_wr_q, last_wr_d;
  logic [NUM_RD-1:0] rd_valid_q, rd_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              gnt_wr, gnt_rd, rd_any;
  logic [RR_W-1:0]   rd_sel;
  logic [CW-1:0]     cand;
  logic [ADDR_W-1:0] rd_sel_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef VRAM_PRELOAD_EN
  localparam int PW = ADDR_W + 1;
  logic [ADDR_W:0] ld_ptr_q, ld_ptr_d;

  // Sequential fill pointer; its top bit marks the end of LOAD.
  always_comb begin
    ld_beat  = ld_valid && ld_ready_q;
    ld_addr  = ld_ptr_q[ADDR_W-1:0];
    ld_ptr_d = ld_ptr_q;
    if (ld_beat) begin
      ld_ptr_d = ld_ptr_q + PW'(1);
    end else begin
      ld_ptr_d = ld_ptr_q;
    end
    loaded_d   = ld_ptr_d[ADDR_W];
    ld_ready_d = ~ld_ptr_d[ADDR_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_ptr_q <= '0;
    end else begin
      ld_ptr_q <= ld_ptr_d;
    end
  end
`else
  logic unused_ld_valid;
  assign unused_ld_valid = ld_valid;

  always_comb begin
    ld_beat    = 1'b0;
    ld_addr    = '0;
    loaded_d   = 1'b1;
    ld_ready_d = 1'b0;
  end
`endif

  // Round-robin search over requesting channels starting at rr_q, then write/read choice.
  always_comb begin
    rd_any = 1'b0;
    rd_sel = rr_q;
    cand   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      cand = {1'b0, rr_q} + CW'(k);
      if (cand >= CW'(NUM_RD)) begin
        cand = cand - CW'(NUM_RD);
      end else begin
        cand = cand;
      end
      if (!rd_any && rd_req[cand[RR_W-1:0]]) begin
        rd_any = 1'b1;
        rd_sel = cand[RR_W-1:0];
      end else begin
        rd_any = rd_any;
      end
    end

    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (loaded_q) begin
      // A write yields once to any pending read after it has just been served.
      if (wr_req && !(last_wr_q && rd_any)) begin
        gnt_wr = 1'b1;
      end else begin
        gnt_rd = rd_any;
      end
    end else begin
      gnt_wr = 1'b0;
    end
  end

  assign rd_sel_addr = rd_addr[int'(rd_sel)*ADDR_W +: ADDR_W];

  // Next-state for the arbiter and the registered response outputs.
  always_comb begin
    rr_d       = rr_q;
    last_wr_d  = last_wr_q;
    rd_valid_d = '0;
    wr_ack_d   = gnt_wr;
    rd_data_d  = rd_data_q;
    if (gnt_rd) begin
      rd_valid_d = NUM_RD'(1) << rd_sel;
      rd_data_d  = mem[rd_sel_addr];
      rr_d       = (rd_sel == RR_W'(NUM_RD-1)) ? '0 : rd_sel + RR_W'(1);
      last_wr_d  = 1'b0;
    end else if (gnt_wr) begin
      last_wr_d = 1'b1;
    end else begin
      last_wr_d = last_wr_q;
    end
  end

  // Only one source can write per cycle: preload beats only occur before loaded.
  always_comb begin
    mem_we = ld_beat | gnt_wr;
    if (ld_beat) begin
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
    end else begin
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loaded_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      rr_q       <= '0;
      last_wr_q  <= 1'b0;
      rd_valid_q <= '0;
      wr_ack_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      loaded_q   <= loaded_d;
      ld_ready_q <= ld_ready_d;
      rr_q       <= rr_d;
      last_wr_q  <= last_wr_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign loaded   = loaded_q;
  assign ld_ready = ld_ready_q;
  assign rd_valid = rd_valid_q;
  assign wr_ack   = wr_ack_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Scoreboard bench for vram_ctrl (ADDR_W=4, NUM_RD=2); covers both VRAM_PRELOAD_EN builds.
module tb_vram_ctrl;

  typedef struct packed {
    logic [1:0]  rv;
    logic        ack;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        loaded;
  logic [1:0]  rd_req;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;

  int          total = 0;
  int          bad = 0;
  logic [15:0] ref_mem [16];
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  vram_ctrl #(.ADDR_W(4), .DATA_W(16), .NUM_RD(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .loaded(loaded),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  task automatic test_reset();
    reset_n = 1'b0; ld_valid = 1'b0; ld_data = 16'h0000; rd_req = 2'b00; rd_addr = 8'h00;
    wr_req = 1'b0; wr_addr = 4'h0; wr_data = 16'h0000;
    repeat (2) @(negedge clk);
    total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    total++; if (rd_valid !== 2'b00) begin bad++; $display("FAIL reset_rd_valid: got %b want 00", rd_valid); end
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
    reset_n = 1'b1;
    @(negedge clk);
`ifdef VRAM_PRELOAD_EN
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL release_ld_ready: got %b want 1", ld_ready); end
    total++; if (loaded !== 1'b0) begin bad++; $display("FAIL release_loaded: got %b want 0", loaded); end
`else
    total++; if (loaded !== 1'b1) begin bad++; $display("FAIL release_loaded: got %b want 1", loaded); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL release_ld_ready: got %b want 0", ld_ready); end
`endif
  endtask

`ifdef VRAM_PRELOAD_EN
  // Drives n_beats preload words base+i, dropping ld_valid every third cycle.
  task automatic preload_stream(input logic [15:0] base, input int n_beats);
    logic [4:0] beats = 5'd0;
    int cyc = 0;
    logic exp_loaded;
    while (int'(beats) < n_beats && cyc < 200) begin
      @(negedge clk);
      total++; if (loaded !== 1'b0) begin bad++; $display("FAIL load_early: beat=%0d got loaded=%b want 0", beats, loaded); end
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready: beat=%0d got %b want 1", beats, ld_ready); end
      total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL load_quiet: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
      ld_valid = ((cyc % 3) != 2);
      ld_data  = base + 16'(beats);
      if (ld_valid && ld_ready) begin
        ref_mem[beats[3:0]] = ld_data;
        beats = beats + 5'd1;
      end
      cyc++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    exp_loaded = (n_beats == 16);
    total++; if (loaded !== exp_loaded) begin bad++; $display("FAIL load_done: got loaded=%b want %b", loaded, exp_loaded); end
    total++; if (ld_ready !== ~exp_loaded) begin bad++; $display("FAIL load_ready_end: got %b want %b", ld_ready, ~exp_loaded); end
  endtask

  task automatic test_preload();
    int cyc;
    exp_t e;
    rd_addr[3:0] = 4'd5;
    rd_req = 2'b01;
    preload_stream(16'h1000, 16);
    exp_q.push_back(exp_t'{2'b01, 1'b0, 16'h1005});
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        rd_addr[7:4] = 4'd15; rd_req = 2'b10;
        exp_q.push_back(exp_t'{2'b10, 1'b0, 16'h100F});
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
        @(negedge clk); cyc++;
        if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
          e = exp_q.pop_front();
          total++;
          if (rd_valid !== e.rv || wr_ack !== e.ack || rd_data !== e.data) begin
            bad++; $display("FAIL preload_read: got rv=%b ack=%b data=%h want rv=%b ack=%b data=%h", rd_valid, wr_ack, rd_data, e.rv, e.ack, e.data);
          end
          rd_req = rd_req & ~rd_valid;
        end
      end
      total++;
      if (exp_q.size() != 0 || cyc != 1) begin bad++; $display("FAIL preload_read_latency: cycles=%0d pending=%0d want 1/0", cyc, exp_q.size()); exp_q.delete(); end
      @(negedge clk);
      total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL preload_idle: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    exp_t e;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    preload_stream(16'h2000, 7);
    reset_n = 1'b0;
    #1;
    total++; if (loaded !== 1'b0 || ld_ready !== 1'b0) begin bad++; $display("FAIL midreset_flags: got loaded=%b ld_ready=%b want 0/0", loaded, ld_ready); end
    total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL midreset_pulses: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
    total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL midreset_rd_data: got %h want 0000", rd_data); end
    @(negedge clk);
    reset_n = 1'b1;
    preload_stream(16'h3000, 16);
    rd_addr = {4'd15, 4'd0};
    rd_req = 2'b11;
    exp_q.push_back(exp_t'{2'b01, 1'b0, ref_mem[0]});
    exp_q.push_back(exp_t'{2'b10, 1'b0, ref_mem[15]});
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== e.rv || wr_ack !== e.ack || rd_data !== e.data) begin
          bad++; $display("FAIL restart_read: got rv=%b ack=%b data=%h want rv=%b ack=%b data=%h", rd_valid, wr_ack, rd_data, e.rv, e.ack, e.data);
        end
        rd_req = rd_req & ~rd_valid;
      end
    end
    total++;
    if (exp_q.size() != 0 || cyc != 2) begin bad++; $display("FAIL restart_timing: cycles=%0d pending=%0d want 2/0", cyc, exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL restart_idle: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
  endtask
`else
  task automatic test_no_preload();
    int cyc;
    exp_t e;
    logic [4:0] n;
    wr_addr = 4'd0; wr_data = 16'h00AA; wr_req = 1'b1;
    ref_mem[0] = 16'h00AA;
    exp_q.push_back(exp_t'{2'b00, 1'b1, 16'h0000});
    for (int i = 1; i < 16; i++) begin
      ref_mem[i] = 16'h2000 + 16'(i);
      exp_q.push_back(exp_t'{2'b00, 1'b1, 16'h0000});
    end
    n = 5'd0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== e.rv || wr_ack !== e.ack) begin
          bad++; $display("FAIL fill_write: got rv=%b ack=%b want rv=%b ack=%b", rd_valid, wr_ack, e.rv, e.ack);
        end
        n = n + 5'd1;
        if (exp_q.size() == 0) begin
          wr_req = 1'b0;
        end else begin
          wr_addr = n[3:0]; wr_data = ref_mem[n[3:0]];
        end
      end
    end
    total++;
    if (exp_q.size() != 0 || cyc != 16) begin bad++; $display("FAIL fill_timing: cycles=%0d pending=%0d want 16/0", cyc, exp_q.size()); exp_q.delete(); wr_req = 1'b0; end
    rd_addr = {4'd15, 4'd0};
    rd_req = 2'b11;
    exp_q.push_back(exp_t'{2'b01, 1'b0, 16'h00AA});
    exp_q.push_back(exp_t'{2'b10, 1'b0, ref_mem[15]});
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== e.rv || wr_ack !== e.ack || rd_data !== e.data) begin
          bad++; $display("FAIL nopre_read: got rv=%b ack=%b data=%h want rv=%b ack=%b data=%h", rd_valid, wr_ack, rd_data, e.rv, e.ack, e.data);
        end
        rd_req = rd_req & ~rd_valid;
      end
    end
    total++;
    if (exp_q.size() != 0 || cyc != 2) begin bad++; $display("FAIL nopre_timing: cycles=%0d pending=%0d want 2/0", cyc, exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL nopre_idle: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
  endtask
`endif

  task automatic test_write_read_mix();
    int cyc;
    exp_t e;
    rd_addr = {4'd9, 4'd3};
    wr_addr = 4'd3; wr_data = 16'hBEEF;
    exp_q.push_back(exp_t'{2'b00, 1'b1, 16'h0000});
    ref_mem[3] = 16'hBEEF;
    exp_q.push_back(exp_t'{2'b01, 1'b0, 16'hBEEF});
    exp_q.push_back(exp_t'{2'b10, 1'b0, ref_mem[9]});
    rd_req = 2'b11; wr_req = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== e.rv || wr_ack !== e.ack || (e.ack == 1'b0 && rd_data !== e.data)) begin
          bad++; $display("FAIL mix_order: got rv=%b ack=%b data=%h want rv=%b ack=%b data=%h", rd_valid, wr_ack, rd_data, e.rv, e.ack, e.data);
        end
        rd_req = rd_req & ~rd_valid;
        if (wr_ack) wr_req = 1'b0;
      end
    end
    total++;
    if (exp_q.size() != 0 || cyc != 3) begin bad++; $display("FAIL mix_timing: cycles=%0d pending=%0d want 3/0", cyc, exp_q.size()); exp_q.delete(); end
    rd_req = 2'b00; wr_req = 1'b0;
    @(negedge clk);
    total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL mix_idle: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
  endtask

  task automatic test_round_robin();
    int cyc;
    exp_t e;
    rd_addr = {4'd15, 4'd3};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_t'{2'b01, 1'b0, ref_mem[3]});
      exp_q.push_back(exp_t'{2'b10, 1'b0, ref_mem[15]});
    end
    rd_req = 2'b11;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== e.rv || wr_ack !== e.ack || rd_data !== e.data) begin
          bad++; $display("FAIL rr_order: got rv=%b ack=%b data=%h want rv=%b ack=%b data=%h", rd_valid, wr_ack, rd_data, e.rv, e.ack, e.data);
        end
        if (exp_q.size() == 0) rd_req = 2'b00;
      end
    end
    total++;
    if (exp_q.size() != 0 || cyc != 4) begin bad++; $display("FAIL rr_timing: cycles=%0d pending=%0d want 4/0", cyc, exp_q.size()); exp_q.delete(); end
    rd_req = 2'b00;
    @(negedge clk);
    total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL rr_idle: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
  endtask

  task automatic test_write_starvation();
    int cyc;
    exp_t e;
    logic more_wr, more_rd;
    wr_addr = 4'd7; wr_data = 16'h5A00;
    rd_addr[7:4] = 4'd7;
    exp_q.push_back(exp_t'{2'b00, 1'b1, 16'h0000});
    exp_q.push_back(exp_t'{2'b10, 1'b0, 16'h5A00});
    exp_q.push_back(exp_t'{2'b00, 1'b1, 16'h0000});
    exp_q.push_back(exp_t'{2'b10, 1'b0, 16'h5A01});
    ref_mem[7] = 16'h5A01;
    wr_req = 1'b1; rd_req = 2'b10;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin
        e = exp_q.pop_front();
        total++;
        if (rd_valid !== e.rv || wr_ack !== e.ack || (e.ack == 1'b0 && rd_data !== e.data)) begin
          bad++; $display("FAIL starve_order: got rv=%b ack=%b data=%h want rv=%b ack=%b data=%h", rd_valid, wr_ack, rd_data, e.rv, e.ack, e.data);
        end
        more_wr = 1'b0; more_rd = 1'b0;
        foreach (exp_q[j]) begin
          if (exp_q[j].ack) more_wr = 1'b1;
          if (exp_q[j].rv[1]) more_rd = 1'b1;
        end
        if (wr_ack) begin
          if (more_wr) wr_data = wr_data + 16'h0001;
          else wr_req = 1'b0;
        end
        if (rd_valid[1] && !more_rd) rd_req = 2'b00;
      end
    end
    total++;
    if (exp_q.size() != 0 || cyc != 4) begin bad++; $display("FAIL starve_timing: cycles=%0d pending=%0d want 4/0", cyc, exp_q.size()); exp_q.delete(); end
    wr_req = 1'b0; rd_req = 2'b00;
    @(negedge clk);
    total++; if (rd_valid !== 2'b00 || wr_ack !== 1'b0) begin bad++; $display("FAIL starve_idle: got rv=%b ack=%b want 00/0", rd_valid, wr_ack); end
  endtask

  initial begin
    test_reset();
`ifdef VRAM_PRELOAD_EN
    test_preload();
    test_reset_mid_load();
`else
    test_no_preload();
`endif
    test_write_read_mix();
    test_round_robin();
    test_write_starvation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
